// File: rtl/rs_latch_pkg.sv
// rs_latch_pkg
//   Shared constants for the RS-latch bank arbiter: default bank geometry,
//   the set/clear opcode values and the controller state encoding.
//   No ports (package).
package rs_latch_pkg;

  localparam int N_LATCH_DEF    = 8;
  localparam int SETTLE_CYC_DEF = 2;

  // Command opcode carried on reqX_op.
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Controller states, kept as plain constants so older tools can consume them.
  localparam int         ST_W      = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

endpackage

// File: rtl/rs_latch.sv
// rs_latch
//   Gated RS latch cell as it exists in the bank. While (clk & en) is high,
//   s forces q to 1 and r forces q to 0. Otherwise q holds its value.
//   r and s are never both driven high by the arbiter.
//   Ports:
//     clk : system clock, ANDed with en to form the latch gate
//     en  : gate enable
//     r   : reset input
//     s   : set input
//     q   : stored value
module rs_latch (
  input  logic clk,
  input  logic en,
  input  logic r,
  input  logic s,
  output logic q
);

  always_latch begin
    if (clk && en && (s || r)) begin
      q <= s;
    end
  end

endmodule

// File: rtl/rs_latch_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. When both requesters are valid, the one
//   that did not win last time is granted. Otherwise the single valid one is
//   granted.
//   Ports:
//     valid0, valid1 : request lines
//     last_grant     : id of the previous winner
//     grant_valid    : some requester is granted
//     grant_id       : id of the granted requester (meaningful with grant_valid)
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid1;
    end
  end

endmodule

// File: rtl/rs_latch_arbiter.sv
// rs_latch_arbiter
//   Shares a bank of N_LATCH gated RS latches between two requesters. Each
//   accepted command is carried out in four steps:
//     1. round-robin grant;
//     2. a one-cycle drive of S or R together with the gate enable;
//     3. SETTLE_CYC quiet cycles;
//     4. a readback of Q, reported with a done pulse.
//   Only one write is ever in flight, and R and S are never high together.
//   Ports:
//     Clk, Resetn            : clock, synchronous active-low reset
//     reqX_valid/idx/op      : command from requester X (op 1=set, 0=clear)
//     reqX_ready             : requester X accepted this cycle (IDLE only)
//     R, S, En               : per-latch reset, set and gate enable
//     Q                      : latch outputs for readback
//     done/done_id/done_err  : completion pulse, owning requester,
//                              readback mismatch
//     busy                   : a command is in progress
module rs_latch_arbiter
  import rs_latch_pkg::*;
#(
  parameter int N_LATCH    = N_LATCH_DEF,
  parameter int IDX_W      = 3,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               req0_valid,
  input  logic [IDX_W-1:0]   req0_idx,
  input  logic               req0_op,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [IDX_W-1:0]   req1_idx,
  input  logic               req1_op,
  output logic               req1_ready,
  output logic [N_LATCH-1:0] R,
  output logic [N_LATCH-1:0] S,
  output logic [N_LATCH-1:0] En,
  input  logic [N_LATCH-1:0] Q,
  output logic               done,
  output logic               done_id,
  output logic               done_err,
  output logic               busy
);

  // The counter is loaded with SETTLE_CYC-1 and counts down to zero.
  // That yields exactly SETTLE_CYC cycles in SETTLE.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             grant_valid;
  logic             grant_id;
  logic             in_idle;
  logic [N_LATCH-1:0] sel_oh;
  logic             rb_hit;
  logic             rb_mismatch;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = in_idle & grant_valid & ~grant_id;
  assign req1_ready = in_idle & grant_valid & grant_id;
  assign busy       = ~in_idle;

  // One-hot select of the captured index.
  // An index beyond the bank decodes to all zeros, so it never drives a latch.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Drive only during the single DRIVE cycle.
  // S is driven for a set and R for a clear, never both.
  always_comb begin
    En = '0;
    S  = '0;
    R  = '0;
    if (state_q == ST_DRIVE) begin
      En = sel_oh;
      S  = (op_q == OP_SET) ? sel_oh : '0;
      R  = (op_q == OP_CLR) ? sel_oh : '0;
    end
  end

  // Readback. A missing target latch (no select bit set) always counts as
  // an error.
  always_comb begin
    rb_hit      = |(Q & sel_oh);
    rb_mismatch = ~(|sel_oh) | (rb_hit != op_q);
  end

  assign done     = (state_q == ST_CHECK);
  assign done_id  = done & id_q;
  assign done_err = done & rb_mismatch;

  // Sequencer. A grant is only taken in IDLE, so the cycle after CHECK is
  // the earliest point where a new command can be accepted.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          id_d         = grant_id;
          idx_d        = grant_id ? req1_idx : req0_idx;
          op_d         = grant_id ? req1_op : req0_op;
          last_grant_d = grant_id;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset abandons any command silently.
  // last_grant starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rs_latch_arbiter.sv
// tb_rs_latch_arbiter
//   Drives rs_latch_arbiter against a bank of real rs_latch cells. A readback
//   override can force Q bits to 0. Expected grants, drive patterns, latch
//   contents and error flags come from a small model: the round-robin rule,
//   a bit array of latch contents and the fixed command window length.
module tb_rs_latch_arbiter;

  localparam int NL  = 8;
  localparam int IW  = 3;
  localparam int SC  = 2;
  localparam int WIN = SC + 3;

  logic          Clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          req0_valid = 1'b0, req0_op = 1'b0;
  logic          req1_valid = 1'b0, req1_op = 1'b0;
  logic [IW-1:0] req0_idx = '0, req1_idx = '0;
  logic          req0_ready, req1_ready;
  logic [NL-1:0] R, S, En, Q, q_latch;
  logic [NL-1:0] stuck_mask = '0;
  logic          done, done_id, done_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [NL-1:0] model_q;
  bit          model_last;
  bit          pend_v   [2];
  bit [IW-1:0] pend_idx [2];
  bit          pend_op  [2];

  // Per-window trace
  logic [NL-1:0] trR [WIN];
  logic [NL-1:0] trS [WIN];
  logic [NL-1:0] trEn [WIN];
  logic [NL-1:0] trQ [WIN];
  logic          tr_r0 [WIN];
  logic          tr_r1 [WIN];
  logic          tr_done [WIN];
  logic          tr_did [WIN];
  logic          tr_derr [WIN];
  int            acc_id;

  always #5 Clk = ~Clk;

  rs_latch_arbiter #(.N_LATCH(NL), .IDX_W(IW), .SETTLE_CYC(SC)) dut (
    .Clk(Clk), .Resetn(Resetn),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_op(req1_op), .req1_ready(req1_ready),
    .R(R), .S(S), .En(En), .Q(Q),
    .done(done), .done_id(done_id), .done_err(done_err), .busy(busy)
  );

  for (genvar g = 0; g < NL; g++) begin : g_lat
    rs_latch u_lat (.clk(Clk), .en(En[g]), .r(R[g]), .s(S[g]), .q(q_latch[g]));
  end

  assign Q = q_latch & ~stuck_mask;

  // Per-cycle invariants
  logic done_prev = 1'b0;
  always @(negedge Clk) begin
    #1;
    n_checks++;
    if (((R & S) !== '0) || ($countones(En) > 1) || (req0_ready && req1_ready) || (done && done_prev)) begin
      n_fail++;
      $display("[TB] FAIL invariant: R&S=%h En=%h ready=%b%b done=%b prev=%b, required R&S=0 popcount(En)<=1 single ready no repeated done",
               R & S, En, req0_ready, req1_ready, done, done_prev);
    end
    done_prev = done;
  end

  // Records one command window of WIN cycles, starting in IDLE.
  // The handshake happens at the end of cycle 0. Unless hold is set, the
  // accepted requester drops valid afterwards.
  task automatic run_window(input bit hold);
    acc_id = -1;
    for (int k = 0; k < WIN; k++) begin
      #1;
      trR[k] = R; trS[k] = S; trEn[k] = En; trQ[k] = Q;
      tr_r0[k] = req0_ready; tr_r1[k] = req1_ready;
      tr_done[k] = done; tr_did[k] = done_id; tr_derr[k] = done_err;
      if (k == 0) begin
        if (req0_ready === 1'b1) acc_id = 0;
        else if (req1_ready === 1'b1) acc_id = 1;
      end
      @(negedge Clk);
      if (k == 0 && !hold) begin
        if (acc_id == 0) req0_valid = 1'b0;
        if (acc_id == 1) req1_valid = 1'b0;
      end
    end
  endtask

  task automatic drive_pending();
    req0_valid = pend_v[0]; req0_idx = pend_idx[0]; req0_op = pend_op[0];
    req1_valid = pend_v[1]; req1_idx = pend_idx[1]; req1_op = pend_op[1];
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    n_checks++;
    if ({busy, done, done_id, done_err, req0_ready, req1_ready} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got %b, expected 000000", {busy, done, done_id, done_err, req0_ready, req1_ready});
    end
    n_checks++;
    if ((R | S | En) !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_drive: got R|S|En=%h, expected 00", R | S | En);
    end
    Resetn = 1'b1;
    model_last = 1'b1;
    @(negedge Clk);
  endtask

  // Clears every latch through requester 0 so the bank starts from a known value.
  task automatic test_init();
    for (int i = 0; i < NL; i++) begin
      req0_valid = 1'b1; req0_idx = IW'(i); req0_op = 1'b0;
      run_window(1'b0);
      n_checks++;
      if (acc_id !== 0 || tr_done[WIN-1] !== 1'b1 || tr_derr[WIN-1] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL init_clear[%0d]: got grant=%0d done=%b err=%b, expected grant=0 done=1 err=0",
                 i, acc_id, tr_done[WIN-1], tr_derr[WIN-1]);
      end
      model_q[i] = 1'b0;
      model_last = 1'b0;
    end
    #1;
    n_checks++;
    if (Q !== (model_q & ~stuck_mask)) begin
      n_fail++;
      $display("[TB] FAIL init_q: got %h, expected %h", Q, model_q & ~stuck_mask);
    end
  endtask

  task automatic test_single_set();
    bit quiet;
    req0_valid = 1'b1; req0_idx = 3'd3; req0_op = 1'b1;
    run_window(1'b0);
    n_checks++;
    if (tr_r0[0] !== 1'b1 || tr_r1[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL set_ready: got r0=%b r1=%b, expected r0=1 r1=0", tr_r0[0], tr_r1[0]);
    end
    n_checks++;
    if (trS[1] !== 8'h08 || trEn[1] !== 8'h08 || trR[1] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL set_drive: got S=%h En=%h R=%h, expected S=08 En=08 R=00", trS[1], trEn[1], trR[1]);
    end
    quiet = 1'b1;
    for (int k = 2; k < WIN - 1; k++) if (tr_done[k] !== 1'b0 || (trR[k] | trS[k] | trEn[k]) !== '0) quiet = 1'b0;
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("[TB] FAIL set_settle: got activity during settle, expected none");
    end
    n_checks++;
    if (tr_done[WIN-1] !== 1'b1 || tr_did[WIN-1] !== 1'b0 || tr_derr[WIN-1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL set_done: got done=%b id=%b err=%b, expected 1 0 0", tr_done[WIN-1], tr_did[WIN-1], tr_derr[WIN-1]);
    end
    n_checks++;
    if (trQ[WIN-1] !== 8'h08) begin
      n_fail++;
      $display("[TB] FAIL set_q: got %h, expected 08", trQ[WIN-1]);
    end
    model_q[3] = 1'b1;
    model_last = 1'b0;
  endtask

  task automatic test_single_clear();
    req1_valid = 1'b1; req1_idx = 3'd3; req1_op = 1'b0;
    run_window(1'b0);
    n_checks++;
    if (tr_r1[0] !== 1'b1 || tr_r0[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_ready: got r0=%b r1=%b, expected r0=0 r1=1", tr_r0[0], tr_r1[0]);
    end
    n_checks++;
    if (trR[1] !== 8'h08 || trS[1] !== 8'h00 || trEn[1] !== 8'h08 || trR[2] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL clr_drive: got R=%h S=%h En=%h R(next)=%h, expected 08 00 08 00", trR[1], trS[1], trEn[1], trR[2]);
    end
    n_checks++;
    if (tr_done[WIN-1] !== 1'b1 || tr_did[WIN-1] !== 1'b1 || tr_derr[WIN-1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_done: got done=%b id=%b err=%b, expected 1 1 0", tr_done[WIN-1], tr_did[WIN-1], tr_derr[WIN-1]);
    end
    n_checks++;
    if (trQ[WIN-1] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL clr_q: got %h, expected 00", trQ[WIN-1]);
    end
    model_q[3] = 1'b0;
    model_last = 1'b1;
  endtask

  // Command stream against the model. With force_both, both requesters
  // are kept busy so grants must alternate. Otherwise requesters refill
  // at random.
  task automatic test_stream(input string name, input int n_cmds, input bit force_both);
    logic [NL-1:0] oh, eff;
    int exp_id;
    bit exp_err, quiet;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    for (int c = 0; c < n_cmds; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend_v[r] && (force_both || $urandom_range(0, 2) != 0)) begin
          pend_v[r] = 1'b1;
          pend_idx[r] = IW'($urandom_range(0, NL - 1));
          pend_op[r] = 1'($urandom_range(0, 1));
        end
      end
      if (!pend_v[0] && !pend_v[1]) begin
        pend_v[0] = 1'b1; pend_idx[0] = IW'($urandom_range(0, NL - 1)); pend_op[0] = 1'($urandom_range(0, 1));
      end
      exp_id = (pend_v[0] && pend_v[1]) ? (model_last ? 0 : 1) : (pend_v[1] ? 1 : 0);
      oh = '0;
      oh[pend_idx[exp_id]] = 1'b1;
      drive_pending();
      run_window(force_both);
      model_q[pend_idx[exp_id]] = pend_op[exp_id];
      model_last = exp_id[0];
      eff = model_q & ~stuck_mask;
      exp_err = (eff[pend_idx[exp_id]] != pend_op[exp_id]);
      n_checks++;
      if (acc_id !== exp_id) begin
        n_fail++;
        $display("[TB] FAIL %s_grant[%0d]: got %0d, expected %0d", name, c, acc_id, exp_id);
      end
      n_checks++;
      if (trEn[1] !== oh || trS[1] !== (pend_op[exp_id] ? oh : 8'h00) || trR[1] !== (pend_op[exp_id] ? 8'h00 : oh)) begin
        n_fail++;
        $display("[TB] FAIL %s_drive[%0d]: got En=%h S=%h R=%h, expected En=%h op=%b", name, c, trEn[1], trS[1], trR[1], oh, pend_op[exp_id]);
      end
      quiet = 1'b1;
      for (int k = 1; k < WIN; k++) if (tr_r0[k] !== 1'b0 || tr_r1[k] !== 1'b0) quiet = 1'b0;
      for (int k = 2; k < WIN - 1; k++) if (tr_done[k] !== 1'b0 || (trR[k] | trS[k] | trEn[k]) !== '0) quiet = 1'b0;
      n_checks++;
      if (!quiet) begin
        n_fail++;
        $display("[TB] FAIL %s_busy_quiet[%0d]: got ready/drive/done activity while busy, expected none", name, c);
      end
      n_checks++;
      if (tr_done[WIN-1] !== 1'b1 || tr_did[WIN-1] !== exp_id[0] || tr_derr[WIN-1] !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL %s_done[%0d]: got done=%b id=%b err=%b, expected 1 %b %b", name, c, tr_done[WIN-1], tr_did[WIN-1], tr_derr[WIN-1], exp_id[0], exp_err);
      end
      n_checks++;
      if (trQ[WIN-1] !== eff) begin
        n_fail++;
        $display("[TB] FAIL %s_q[%0d]: got %h, expected %h", name, c, trQ[WIN-1], eff);
      end
      pend_v[exp_id] = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_stuck_readback();
    stuck_mask = 8'h20;
    req0_valid = 1'b1; req0_idx = 3'd5; req0_op = 1'b1;
    run_window(1'b0);
    model_q[5] = 1'b1;
    model_last = 1'b0;
    n_checks++;
    if (acc_id !== 0 || tr_done[WIN-1] !== 1'b1 || tr_derr[WIN-1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stuck_err: got grant=%0d done=%b err=%b, expected 0 1 1", acc_id, tr_done[WIN-1], tr_derr[WIN-1]);
    end
    req1_valid = 1'b1; req1_idx = 3'd6; req1_op = 1'b1;
    run_window(1'b0);
    model_q[6] = 1'b1;
    model_last = 1'b1;
    n_checks++;
    if (acc_id !== 1 || tr_done[WIN-1] !== 1'b1 || tr_did[WIN-1] !== 1'b1 || tr_derr[WIN-1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stuck_next: got grant=%0d done=%b id=%b err=%b, expected 1 1 1 0", acc_id, tr_done[WIN-1], tr_did[WIN-1], tr_derr[WIN-1]);
    end
    stuck_mask = 8'h00;
    #1;
    n_checks++;
    if (Q !== model_q) begin
      n_fail++;
      $display("[TB] FAIL stuck_release_q: got %h, expected %h", Q, model_q);
    end
  endtask

  task automatic test_reset_mid_command();
    bit quiet;
    req0_valid = 1'b1; req0_idx = 3'd2; req0_op = 1'b1; req1_valid = 1'b0;
    @(negedge Clk);
    req0_valid = 1'b0;
    @(negedge Clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_busy_before: got %b, expected 1", busy);
    end
    Resetn = 1'b0;
    @(negedge Clk);
    #1;
    n_checks++;
    if ({busy, done, done_id, done_err} !== 4'b0 || (R | S | En) !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_state: got busy/done/id/err=%b R|S|En=%h, expected 0000 00", {busy, done, done_id, done_err}, R | S | En);
    end
    Resetn = 1'b1;
    model_q[2] = 1'b1;
    model_last = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("[TB] FAIL midreset_no_done: got done or busy after abandoned command, expected none");
    end
    n_checks++;
    if (Q !== model_q) begin
      n_fail++;
      $display("[TB] FAIL midreset_q: got %h, expected %h", Q, model_q);
    end
    // Both requesters hit latch 4 with opposite ops: req0 first, then req1's clear wins.
    req0_valid = 1'b1; req0_idx = 3'd4; req0_op = 1'b1;
    req1_valid = 1'b1; req1_idx = 3'd4; req1_op = 1'b0;
    run_window(1'b0);
    n_checks++;
    if (acc_id !== 0 || tr_did[WIN-1] !== 1'b0 || trQ[WIN-1][4] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_first_grant: got grant=%0d id=%b q4=%b, expected 0 0 1", acc_id, tr_did[WIN-1], trQ[WIN-1][4]);
    end
    run_window(1'b0);
    model_q[4] = 1'b0;
    model_last = 1'b1;
    n_checks++;
    if (acc_id !== 1 || tr_did[WIN-1] !== 1'b1 || trQ[WIN-1] !== model_q) begin
      n_fail++;
      $display("[TB] FAIL same_idx_serialize: got grant=%0d id=%b Q=%h, expected 1 1 %h", acc_id, tr_did[WIN-1], trQ[WIN-1], model_q);
    end
  endtask

  task automatic test_back_to_back_req1();
    bit r0_seen;
    r0_seen = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req1_idx = IW'(c);
      run_window(1'b1);
      for (int k = 0; k < WIN; k++) if (tr_r0[k] !== 1'b0) r0_seen = 1'b1;
      n_checks++;
      if (acc_id !== 1 || tr_done[WIN-1] !== 1'b1 || tr_did[WIN-1] !== 1'b1 || tr_derr[WIN-1] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL b2b_cmd[%0d]: got grant=%0d done=%b id=%b err=%b, expected 1 1 1 0", c, acc_id, tr_done[WIN-1], tr_did[WIN-1], tr_derr[WIN-1]);
      end
      model_q[c] = 1'b1;
    end
    req1_valid = 1'b0;
    model_last = 1'b1;
    n_checks++;
    if (r0_seen) begin
      n_fail++;
      $display("[TB] FAIL b2b_req0_ready: got 1 at some cycle, expected 0 throughout");
    end
    n_checks++;
    if (trQ[WIN-1] !== 8'h07) begin
      n_fail++;
      $display("[TB] FAIL b2b_q: got %h, expected 07", trQ[WIN-1]);
    end
  endtask

  initial begin
    $display("[TB] rs_latch_arbiter bench start");
    test_reset();
    test_init();
    test_single_set();
    test_single_clear();
    test_stream("contention", 4, 1'b1);
    test_stuck_readback();
    test_reset_mid_command();
    test_init();
    test_back_to_back_req1();
    test_stream("random", 30, 1'b0);
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
